ss_xfer_fifo: RTL and testbench

//  64-bit data buffer between source-side ss_sg (rw=0, memory read) and destination-side ss_sg (rw=1, memory write).

---
 rtl/ss_xfer_fifo_if.sv | 37 +++
 rtl/ss_xfer_fifo.sv | 131 +++++++++++++
 tb/tb_ss_xfer_fifo.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ss_xfer_fifo_if.sv
// Bus bundle between ss_xfer_fifo and the surrounding ss_adma / ss_sg logic.
// Handshake: src_xfer / dst_xfer are single-cycle transfer strobes with no
// back-pressure; each side's ss_sg paces itself from *_start / *_stop, which
// it samples in the same cycle as the strobe. *_end marks that side as done.
interface ss_xfer_fifo_if #(
  parameter int AW = 4
);
  logic          job_go;
  logic          ss_done;
  logic [63:0]   src_dat_i;
  logic          src_xfer;
  logic          src_last;
  logic          src_start;
  logic          src_stop;
  logic          src_end;
  logic [63:0]   dst_dat_o;
  logic          dst_xfer;
  logic          dst_start;
  logic          dst_stop;
  logic          dst_end;
  logic [AW:0]   fifo_cnt;
  logic          ovf_err;
  logic          unf_err;
  logic [1:0]    dbg_state;

  modport slave (
    input  job_go, ss_done, src_dat_i, src_xfer, src_last, dst_xfer,
    output src_start, src_stop, src_end, dst_dat_o, dst_start, dst_stop,
           dst_end, fifo_cnt, ovf_err, unf_err, dbg_state
  );

  modport master (
    output job_go, ss_done, src_dat_i, src_xfer, src_last, dst_xfer,
    input  src_start, src_stop, src_end, dst_dat_o, dst_start, dst_stop,
           dst_end, fifo_cnt, ovf_err, unf_err, dbg_state
  );
endinterface

// File: rtl/ss_xfer_fifo.sv
// 64-bit first-word-fall-through buffer between the source (memory read) and
// destination (memory write) scatter-gather engines. Flow-control strobes for
// both sides are derived combinationally from the job state and fill level.
module ss_xfer_fifo #(
  parameter int AW    = 4,
  parameter int BURST = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  ss_xfer_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [AW:0]   L_DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   L_DEPTH_M1 = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0]   L_BURST    = (AW+1)'(BURST);
  localparam logic [AW:0]   L_ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] L_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [63:0]   r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [1:0]    r_state;
  logic          r_last_seen;
  logic          r_ovf;
  logic          r_unf;

  logic          w_push;
  logic          w_pop;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_ovf_evt;
  logic          w_unf_evt;
  logic          w_active;
  logic [AW:0]   w_free;
  logic [AW:0]   w_cnt_nxt;

  // A push at full still lands if a pop frees the slot in the same cycle;
  // a pop on empty never moves the read pointer.
  assign w_push    = bus.src_xfer & ~bus.src_last & (r_state == S_RUN);
  assign w_pop     = bus.dst_xfer & (r_state != S_IDLE);
  assign w_do_pop  = w_pop & (r_cnt != '0);
  assign w_do_push = w_push & ((r_cnt != L_DEPTH) | w_do_pop);
  assign w_ovf_evt = w_push & ~w_do_push;
  assign w_unf_evt = w_pop & ~w_do_pop;
  assign w_active  = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_free    = L_DEPTH - r_cnt;

  // Next fill level after this cycle's accepted push/pop.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop)
      w_cnt_nxt = r_cnt + L_ONE;
    else if (w_do_pop && !w_do_push)
      w_cnt_nxt = r_cnt - L_ONE;
  end

  // Storage array: contents are don't-care until written, so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= bus.src_dat_i;
  end

  // Job FSM plus pointer/count/error bookkeeping; ss_done flushes from any
  // active state and wins over every other transition.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_last_seen <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (bus.ss_done && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_last_seen <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      r_cnt <= w_cnt_nxt;
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_unf_evt) r_unf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.job_go) begin
            r_state     <= S_RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.src_xfer && bus.src_last) begin
            r_last_seen <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_cnt_nxt == '0)
            r_state <= S_END;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign bus.dst_dat_o = (r_cnt != '0) ? r_mem[r_rd_ptr] : 64'd0;
  assign bus.src_start = (r_state == S_RUN) & (w_free >= L_BURST);
  assign bus.src_stop  = (r_state == S_RUN) & (r_cnt >= L_DEPTH_M1);
  assign bus.src_end   = (r_state == S_DRAIN) | (r_state == S_END);
  assign bus.dst_start = w_active & ((r_cnt >= L_BURST) | (r_last_seen & (r_cnt != '0)));
  assign bus.dst_stop  = w_active & (r_cnt <= L_ONE);
  assign bus.dst_end   = (r_state == S_END);
  assign bus.fifo_cnt  = r_cnt;
  assign bus.ovf_err   = r_ovf;
  assign bus.unf_err   = r_unf;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ss_xfer_fifo.sv
// Directed bench for ss_xfer_fifo: a vector table for the basic job flow,
// then hand-written sequences for fill/overflow, wrap streaming, drain/end,
// underflow, ss_done flush and asynchronous reset.
module tb_ss_xfer_fifo;
  localparam int AW = 4;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;

  ss_xfer_fifo_if #(.AW(AW)) bus ();

  ss_xfer_fifo #(.AW(AW), .BURST(4)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  // Clock and reset
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        go;
    logic        done;
    logic        sx;
    logic        sl;
    logic [63:0] sd;
    logic        dx;
    logic [4:0]  cnt;
    logic [5:0]  flow;   // {src_start, src_stop, src_end, dst_start, dst_stop, dst_end}
    logic [63:0] dat;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flow_now();
    return {bus.src_start, bus.src_stop, bus.src_end,
            bus.dst_start, bus.dst_stop, bus.dst_end};
  endfunction

  // Driver: apply inputs for one clock edge, then return them to idle.
  task automatic cyc(input logic go, input logic done, input logic sx,
                     input logic sl, input logic [63:0] sd, input logic dx);
    bus.job_go    = go;
    bus.ss_done   = done;
    bus.src_xfer  = sx;
    bus.src_last  = sl;
    bus.src_dat_i = sd;
    bus.dst_xfer  = dx;
    @(posedge wb_clk_i);
    #1;
    bus.job_go    = 1'b0;
    bus.ss_done   = 1'b0;
    bus.src_xfer  = 1'b0;
    bus.src_last  = 1'b0;
    bus.src_dat_i = 64'd0;
    bus.dst_xfer  = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
  endtask

  initial begin
    bus.job_go = 1'b0; bus.ss_done = 1'b0; bus.src_xfer = 1'b0;
    bus.src_last = 1'b0; bus.src_dat_i = 64'd0; bus.dst_xfer = 1'b0;

    //            go   done sx   sl   data                    dx   cnt flow       dat                     ovf  unf
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,64'd0,                 1'b0,5'd0,6'b100010,64'd0,                 1'b0,1'b0};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b0,64'h0123_4567_89ab_cdef,1'b0,5'd1,6'b100010,64'h0123_4567_89ab_cdef,1'b0,1'b0};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0,64'hdead_beef_0000_0001,1'b0,5'd2,6'b100000,64'h0123_4567_89ab_cdef,1'b0,1'b0};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,64'hcafe_f00d_0000_0002,1'b0,5'd3,6'b100000,64'h0123_4567_89ab_cdef,1'b0,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,64'h5555_aaaa_0000_0003,1'b0,5'd4,6'b100100,64'h0123_4567_89ab_cdef,1'b0,1'b0};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,64'h1111_2222_0000_0004,1'b1,5'd4,6'b100100,64'hdead_beef_0000_0001,1'b0,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,64'd0,                 1'b1,5'd3,6'b100000,64'hcafe_f00d_0000_0002,1'b0,1'b0};
    vecs[7] = '{1'b0,1'b0,1'b0,1'b0,64'd0,                 1'b1,5'd2,6'b100000,64'h5555_aaaa_0000_0003,1'b0,1'b0};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b0,64'd0,                 1'b0,5'd0,6'b000000,64'd0,                 1'b0,1'b0};

    // Reset state
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("rst_cnt",   64'(bus.fifo_cnt), 64'd0);
    chk("rst_flow",  64'(flow_now()), 64'd0);
    chk("rst_dat",   bus.dst_dat_o, 64'd0);
    chk("rst_err",   64'({bus.ovf_err, bus.unf_err}), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;

    // Vector table: job start, 4 pushes, push+pop, pops, ss_done flush
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].go, vecs[i].done, vecs[i].sx, vecs[i].sl, vecs[i].sd, vecs[i].dx);
      chk($sformatf("vec%0d_cnt", i),  64'(bus.fifo_cnt), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_flow", i), 64'(flow_now()), 64'(vecs[i].flow));
      chk($sformatf("vec%0d_dat", i),  bus.dst_dat_o, vecs[i].dat);
      chk($sformatf("vec%0d_err", i),  64'({bus.ovf_err, bus.unf_err}),
          64'({vecs[i].ovf, vecs[i].unf}));
    end

    // Fill to full, then overflow
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      push(64'h7000_0000_0000_0000 + 64'(i));
      if (i == 12) chk("fill13_src_start", 64'(bus.src_start), 64'd0);
      if (i == 13) chk("fill14_src_stop", 64'(bus.src_stop), 64'd0);
      if (i == 14) chk("fill15_src_stop", 64'(bus.src_stop), 64'd1);
      if (i == 15) begin
        chk("fill16_cnt", 64'(bus.fifo_cnt), 64'd16);
        chk("fill16_src_start", 64'(bus.src_start), 64'd0);
        chk("fill16_ovf", 64'(bus.ovf_err), 64'd0);
      end
    end
    chk("ovf_set", 64'(bus.ovf_err), 64'd1);
    chk("ovf_cnt", 64'(bus.fifo_cnt), 64'd16);
    chk("ovf_head", bus.dst_dat_o, 64'h7000_0000_0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("ovf_sticky_after_done", 64'(bus.ovf_err), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("ovf_clr_by_go", 64'(bus.ovf_err), 64'd0);

    // Streaming push+pop at cnt=5 across pointer wrap
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      exp_q.push_back(d);
      push(d);
    end
    chk("stream_pre_cnt", 64'(bus.fifo_cnt), 64'd5);
    for (int i = 0; i < 20; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      chk($sformatf("stream_head%0d", i), bus.dst_dat_o, exp_q.pop_front());
      exp_q.push_back(d);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, d, 1'b1);
      if (i == 19) chk("stream_cnt", 64'(bus.fifo_cnt), 64'd5);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stream_tail%0d", i), bus.dst_dat_o, exp_q.pop_front());
      pop();
    end
    chk("stream_empty_cnt", 64'(bus.fifo_cnt), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

    // Last marker, drain and end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    push(64'hAAAA_0000_0000_0000);
    push(64'hBBBB_0000_0000_0001);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("drain_cnt", 64'(bus.fifo_cnt), 64'd2);
    chk("drain_flow", 64'(flow_now()), 64'b001100);
    chk("drain_state", 64'(bus.dbg_state), 64'd2);
    pop();
    chk("drain_pop1_dat", bus.dst_dat_o, 64'hBBBB_0000_0000_0001);
    chk("drain_pop1_flow", 64'(flow_now()), 64'b001110);
    pop();
    chk("end_flow", 64'(flow_now()), 64'b001001);
    chk("end_cnt", 64'(bus.fifo_cnt), 64'd0);

    // Underflow in END, then job_go clears it
    pop();
    chk("unf_set", 64'(bus.unf_err), 64'd1);
    chk("unf_cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("unf_dat", bus.dst_dat_o, 64'd0);
    chk("unf_hold_end", 64'(bus.dst_end), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("unf_idle_state", 64'(bus.dbg_state), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("unf_clr_by_go", 64'(bus.unf_err), 64'd0);

    // ss_done with cnt=7 in RUN
    for (int i = 0; i < 7; i++) push(64'h3000 + 64'(i));
    chk("done_pre_cnt", 64'(bus.fifo_cnt), 64'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h9999, 1'b1);
    chk("done_cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("done_flow", 64'(flow_now()), 64'd0);
    chk("done_state", 64'(bus.dbg_state), 64'd0);
    chk("done_dat", bus.dst_dat_o, 64'd0);

    // Asynchronous reset in the middle of a push cycle
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) push(64'h4000 + 64'(i));
    bus.src_xfer  = 1'b1;
    bus.src_dat_i = 64'h4444;
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("arst_flow", 64'(flow_now()), 64'd0);
    chk("arst_dat", bus.dst_dat_o, 64'd0);
    chk("arst_state", 64'(bus.dbg_state), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    wb_rst_i = 1'b0;
    push(64'h5555);
    chk("arst_idle_ignores_push", 64'(bus.fifo_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
